// File: rtl/comb_lock_if.sv
// Keypad-side bundle for the combination lock controller: strobed digit entry,
// relock / reprogram requests, and the registered actuator and status outputs.
interface comb_lock_if #(
  parameter int CODE_LEN  = 4,
  parameter int MAX_FAILS = 3
);
  logic                               digit_valid;
  logic [3:0]                         digit;
  logic                               relock;
  logic                               prog_we;
  logic [4*CODE_LEN-1:0]              prog_code;
  logic                               unlocked;
  logic                               locked_out;
  logic [CODE_LEN-1:0]                progress;
  logic                               fail_pulse;
  logic [$clog2(MAX_FAILS+1)-1:0]     fail_count;

  modport master (
    output digit_valid, digit, relock, prog_we, prog_code,
    input  unlocked, locked_out, progress, fail_pulse, fail_count
  );

  modport slave (
    input  digit_valid, digit, relock, prog_we, prog_code,
    output unlocked, locked_out, progress, fail_pulse, fail_count
  );
endinterface

// File: rtl/comb_lock_ctrl.sv
// Combination lock sequencer: compares a strobed digit sequence against a
// programmable code, holds the unlock window and enforces lockout after repeated failures.
module comb_lock_ctrl #(
  parameter int                      CODE_LEN       = 4,
  parameter logic [4*CODE_LEN-1:0]   RESET_CODE     = 16'h6789,
  parameter int                      UNLOCK_CYCLES  = 30,
  parameter int                      MAX_FAILS      = 3,
  parameter int                      LOCKOUT_CYCLES = 100,
  parameter int                      ENTRY_TIMEOUT  = 50
) (
  input  logic         clk,
  input  logic         rst_n,
  comb_lock_if.slave   bus
);

  localparam int IDX_W   = $clog2(CODE_LEN);
  localparam int FC_W    = $clog2(MAX_FAILS + 1);
  localparam int TMR_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES)
                         ? ((UNLOCK_CYCLES > ENTRY_TIMEOUT) ? UNLOCK_CYCLES : ENTRY_TIMEOUT)
                         : ((LOCKOUT_CYCLES > ENTRY_TIMEOUT) ? LOCKOUT_CYCLES : ENTRY_TIMEOUT);
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(CODE_LEN - 1);
  localparam logic [FC_W-1:0]  MAXF        = FC_W'(MAX_FAILS);
  localparam logic [FC_W-1:0]  MAXF_M1     = FC_W'(MAX_FAILS - 1);
  localparam logic [TMR_W-1:0] T_UNLOCK    = TMR_W'(UNLOCK_CYCLES);
  localparam logic [TMR_W-1:0] T_LOCKOUT   = TMR_W'(LOCKOUT_CYCLES);
  localparam logic [TMR_W-1:0] T_IDLE      = TMR_W'(ENTRY_TIMEOUT);
  localparam logic [TMR_W-1:0] T_ONE       = TMR_W'(1);

  typedef enum logic [1:0] {
    S_ENTRY   = 2'd0,
    S_UNLOCK  = 2'd1,
    S_LOCKOUT = 2'd2
  } state_e;

  state_e                        state_q, state_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic                          mismatch_q, mismatch_d;
  logic [TMR_W-1:0]              timer_q, timer_d;
  logic [CODE_LEN-1:0][3:0]      code_q, code_d;
  logic [CODE_LEN-1:0]           progress_q, progress_d;
  logic                          fail_pulse_q, fail_pulse_d;
  logic [FC_W-1:0]               fail_count_q, fail_count_d;
  logic                          unlocked_q, unlocked_d;
  logic                          locked_out_q, locked_out_d;
  logic                          seq_bad;

  // NOTE: every always_comb output gets a default before the case so no path infers a latch.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    mismatch_d   = mismatch_q;
    timer_d      = timer_q;
    code_d       = code_q;
    progress_d   = progress_q;
    fail_pulse_d = 1'b0;
    fail_count_d = fail_count_q;
    seq_bad      = mismatch_q | (bus.digit != code_q[idx_q]);

    unique case (state_q)
      S_ENTRY: begin
        if (bus.digit_valid) begin
          timer_d           = T_IDLE;
          progress_d[idx_q] = 1'b1;
          if (idx_q != LAST_IDX) begin
            idx_d      = idx_q + 1'b1;
            mismatch_d = seq_bad;
          end else begin
            idx_d      = '0;
            mismatch_d = 1'b0;
            if (!seq_bad) begin
              state_d      = S_UNLOCK;
              timer_d      = T_UNLOCK;
              fail_count_d = '0;
            end else begin
              // Wrong digits are only revealed here, once the whole sequence is in.
              fail_pulse_d = 1'b1;
              progress_d   = '0;
              if (fail_count_q >= MAXF_M1) begin
                fail_count_d = MAXF;
                state_d      = S_LOCKOUT;
                timer_d      = T_LOCKOUT;
              end else begin
                fail_count_d = fail_count_q + 1'b1;
              end
            end
          end
        end else if (idx_q != '0) begin
          if (timer_q == T_ONE) begin
            idx_d      = '0;
            mismatch_d = 1'b0;
            progress_d = '0;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
      end

      S_UNLOCK: begin
        if (bus.prog_we) code_d = bus.prog_code;
        if (bus.relock || timer_q == T_ONE) begin
          state_d    = S_ENTRY;
          progress_d = '0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      S_LOCKOUT: begin
        if (timer_q == T_ONE) begin
          state_d      = S_ENTRY;
          fail_count_d = '0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      default: state_d = S_ENTRY;
    endcase

    unlocked_d   = (state_d == S_UNLOCK);
    locked_out_d = (state_d == S_LOCKOUT);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_ENTRY;
      idx_q        <= '0;
      mismatch_q   <= 1'b0;
      timer_q      <= '0;
      // NOTE: the code is a single register with a defined reset value, not a memory array.
      code_q       <= RESET_CODE;
      progress_q   <= '0;
      fail_pulse_q <= 1'b0;
      fail_count_q <= '0;
      unlocked_q   <= 1'b0;
      locked_out_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      mismatch_q   <= mismatch_d;
      timer_q      <= timer_d;
      code_q       <= code_d;
      progress_q   <= progress_d;
      fail_pulse_q <= fail_pulse_d;
      fail_count_q <= fail_count_d;
      unlocked_q   <= unlocked_d;
      locked_out_q <= locked_out_d;
    end
  end

  assign bus.unlocked   = unlocked_q;
  assign bus.locked_out = locked_out_q;
  assign bus.progress   = progress_q;
  assign bus.fail_pulse = fail_pulse_q;
  assign bus.fail_count = fail_count_q;

endmodule

// File: tb/tb_comb_lock_ctrl.sv
// Bench for comb_lock_ctrl: directed scenarios then random traffic, every cycle
// compared against a sequence-level model of the lock rules.
module tb_comb_lock_ctrl;

  localparam int          CODE_LEN       = 4;
  localparam logic [15:0] RESET_CODE     = 16'h6789;
  localparam int          UNLOCK_CYCLES  = 30;
  localparam int          MAX_FAILS      = 3;
  localparam int          LOCKOUT_CYCLES = 100;
  localparam int          ENTRY_TIMEOUT  = 50;

  localparam int M_ENTRY = 0, M_UNLOCK = 1, M_LOCKOUT = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  comb_lock_if #(.CODE_LEN(CODE_LEN), .MAX_FAILS(MAX_FAILS)) bus ();

  comb_lock_ctrl #(
    .CODE_LEN(CODE_LEN), .RESET_CODE(RESET_CODE), .UNLOCK_CYCLES(UNLOCK_CYCLES),
    .MAX_FAILS(MAX_FAILS), .LOCKOUT_CYCLES(LOCKOUT_CYCLES), .ENTRY_TIMEOUT(ENTRY_TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int n_ul     = 0;
  int n_lo     = 0;

  // Sequence-level model of the lock
  int          m_mode, m_left, m_idle, m_fails, m_shown;
  bit          m_fp;
  logic [3:0]  m_entered[$];
  logic [3:0]  m_code[CODE_LEN];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_code(input logic [15:0] c);
    for (int i = 0; i < CODE_LEN; i++) m_code[i] = c[4*i +: 4];
  endtask

  task automatic model_reset();
    m_mode = M_ENTRY; m_left = 0; m_idle = 0; m_fails = 0; m_shown = 0; m_fp = 1'b0;
    m_entered.delete();
    load_code(RESET_CODE);
  endtask

  task automatic model_step(input bit dv, input logic [3:0] d, input bit rl, input bit pw,
                            input logic [15:0] pc);
    bit ok;
    m_fp = 1'b0;
    case (m_mode)
      M_ENTRY: begin
        if (dv) begin
          m_entered.push_back(d);
          m_idle = 0;
          if (m_entered.size() == CODE_LEN) begin
            ok = 1'b1;
            for (int i = 0; i < CODE_LEN; i++) if (m_entered[i] !== m_code[i]) ok = 1'b0;
            m_entered.delete();
            if (ok) begin
              m_mode = M_UNLOCK; m_left = UNLOCK_CYCLES; m_fails = 0; m_shown = CODE_LEN;
            end else begin
              m_fp = 1'b1; m_shown = 0;
              if (m_fails < MAX_FAILS) m_fails++;
              if (m_fails == MAX_FAILS) begin
                m_mode = M_LOCKOUT; m_left = LOCKOUT_CYCLES;
              end
            end
          end else begin
            m_shown = m_entered.size();
          end
        end else if (m_entered.size() > 0) begin
          m_idle++;
          if (m_idle == ENTRY_TIMEOUT) begin
            m_entered.delete(); m_shown = 0;
          end
        end
      end
      M_UNLOCK: begin
        if (pw) load_code(pc);
        m_left--;
        if (rl || m_left == 0) begin
          m_mode = M_ENTRY; m_shown = 0;
        end
      end
      default: begin
        m_left--;
        if (m_left == 0) begin
          m_mode = M_ENTRY; m_fails = 0;
        end
      end
    endcase
  endtask

  task automatic compare_all();
    check("unlocked",   32'(bus.unlocked),   32'(m_mode == M_UNLOCK));
    check("locked_out", 32'(bus.locked_out), 32'(m_mode == M_LOCKOUT));
    check("progress",   32'(bus.progress),   (32'd1 << m_shown) - 32'd1);
    check("fail_pulse", 32'(bus.fail_pulse), 32'(m_fp));
    check("fail_count", 32'(bus.fail_count), 32'(m_fails));
  endtask

  task automatic cyc(input bit dv, input logic [3:0] d, input bit rl, input bit pw,
                     input logic [15:0] pc);
    @(negedge clk);
    bus.digit_valid = dv; bus.digit = d; bus.relock = rl; bus.prog_we = pw; bus.prog_code = pc;
    model_step(dv, d, rl, pw, pc);
    @(posedge clk);
    #1;
    if (bus.unlocked)   n_ul++;
    if (bus.locked_out) n_lo++;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 4'h0, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic enter_seq(input logic [15:0] s);
    for (int i = 0; i < CODE_LEN; i++) cyc(1'b1, s[4*i +: 4], 1'b0, 1'b0, 16'h0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_unlocked"},   32'(bus.unlocked),   32'd0);
    check({tag, "_locked_out"}, 32'(bus.locked_out), 32'd0);
    check({tag, "_progress"},   32'(bus.progress),   32'd0);
    check({tag, "_fail_pulse"}, 32'(bus.fail_pulse), 32'd0);
    check({tag, "_fail_count"}, 32'(bus.fail_count), 32'd0);
  endtask

  initial begin
    bus.digit_valid = 1'b0; bus.digit = 4'h0; bus.relock = 1'b0;
    bus.prog_we = 1'b0; bus.prog_code = 16'h0;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // T1: correct code, full unlock window
    enter_seq(16'h6789);
    check("t1_unlocked_after_4th", 32'(bus.unlocked), 32'd1);
    check("t1_progress_full", 32'(bus.progress), 32'hF);
    n_ul = 1;
    idle(UNLOCK_CYCLES + 5);
    check("t1_unlock_window_len", n_ul, UNLOCK_CYCLES);

    // T2: one wrong digit
    enter_seq(16'h6089);
    check("t2_fail_pulse", 32'(bus.fail_pulse), 32'd1);
    check("t2_fail_count", 32'(bus.fail_count), 32'd1);
    idle(2);

    // T3: lockout; correct code and reprogramming during lockout are ignored
    enter_seq(16'h0000);
    enter_seq(16'h1234);
    check("t3_locked_out", 32'(bus.locked_out), 32'd1);
    n_lo = 1;
    enter_seq(16'h6789);
    cyc(1'b0, 4'h0, 1'b1, 1'b1, 16'h1111);
    idle(LOCKOUT_CYCLES);
    check("t3_lockout_window_len", n_lo, LOCKOUT_CYCLES);
    check("t3_fail_count_cleared", 32'(bus.fail_count), 32'd0);
    enter_seq(16'h6789);
    check("t3_unlock_after_lockout", 32'(bus.unlocked), 32'd1);

    // T4: reprogram together with relock, new code works, old code fails
    cyc(1'b0, 4'h0, 1'b1, 1'b1, 16'h4321);
    check("t4_relock_exit", 32'(bus.unlocked), 32'd0);
    enter_seq(16'h4321);
    check("t4_new_code_unlocks", 32'(bus.unlocked), 32'd1);
    cyc(1'b0, 4'h0, 1'b0, 1'b1, 16'h6789);
    cyc(1'b0, 4'h0, 1'b1, 1'b0, 16'h0);
    enter_seq(16'h4321);
    check("t4_stale_code_fails", 32'(bus.fail_pulse), 32'd1);
    enter_seq(16'h6789);

    // T5: idle timeout discards a partial entry; digit on the expiry cycle wins
    cyc(1'b0, 4'h0, 1'b1, 1'b0, 16'h0);
    cyc(1'b1, 4'h9, 1'b0, 1'b0, 16'h0);
    cyc(1'b1, 4'h8, 1'b0, 1'b0, 16'h0);
    idle(ENTRY_TIMEOUT);
    check("t5_timeout_progress", 32'(bus.progress), 32'd0);
    enter_seq(16'h6789);
    check("t5_unlock_after_timeout", 32'(bus.unlocked), 32'd1);
    cyc(1'b0, 4'h0, 1'b1, 1'b0, 16'h0);
    cyc(1'b1, 4'h9, 1'b0, 1'b0, 16'h0);
    cyc(1'b1, 4'h8, 1'b0, 1'b0, 16'h0);
    idle(ENTRY_TIMEOUT - 1);
    cyc(1'b1, 4'h7, 1'b0, 1'b0, 16'h0);
    check("t5_expiry_digit_kept", 32'(bus.progress), 32'h7);
    cyc(1'b1, 4'h6, 1'b0, 1'b0, 16'h0);
    check("t5_unlock_via_expiry_digit", 32'(bus.unlocked), 32'd1);

    // T6: reset mid-unlock after reprogramming
    cyc(1'b0, 4'h0, 1'b0, 1'b1, 16'h1111);
    idle(3);
    @(negedge clk);
    bus.prog_we = 1'b0; bus.relock = 1'b0; bus.digit_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("t6_reset");
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    enter_seq(16'h6789);
    check("t6_reset_code_restored", 32'(bus.unlocked), 32'd1);

    // Random traffic
    for (int i = 0; i < 2500; i++) begin
      bit         dv, rl, pw;
      logic [3:0] d;
      logic [15:0] pc;
      dv = ($urandom_range(2) == 0);
      d  = ($urandom_range(1) == 0 && m_entered.size() < CODE_LEN)
         ? m_code[m_entered.size()] : 4'($urandom_range(15));
      rl = ($urandom_range(19) == 0);
      pw = ($urandom_range(29) == 0);
      pc = ($urandom_range(1) == 0) ? RESET_CODE : 16'($urandom);
      if ($urandom_range(99) == 0) idle($urandom_range(ENTRY_TIMEOUT + 10, 1));
      cyc(dv, d, rl, pw, pc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
